// File: rtl/rv_pkg.sv
// Shared integer-register definitions used by the register file, decode and
// writeback stages.
package rv_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set at
// issue and cleared at writeback, with a per-read-port busy lookup.
module regfile_scoreboard
   import rv_pkg::*;
#(
   parameter int NREGS  = NREGS_DEFAULT,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic                 sb_set,
   input  logic [AW-1:0]        sb_addr,
   input  logic [NUM_RD*AW-1:0] raddr,
   output logic [NREGS-1:0]     busy_vec,
   output logic [NUM_RD-1:0]    rbusy
);

   logic [NREGS-1:0] busy_q, busy_d;

   // Set dominates clear: a freshly issued producer supersedes the one
   // completing in the same cycle.
   always_comb begin
      busy_d    = busy_q;
      busy_d[0] = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         busy_d[r] = (sb_set && (sb_addr == AW'(r))) ||
                     (busy_q[r] && !(we && (waddr == AW'(r))));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0] a;
      logic          wr_hit;

      assign a = raddr[p*AW +: AW];

      // With forwarding, a completing write already satisfies the reader.
      if (BYPASS != 0) begin : g_byp
         assign wr_hit = we && (waddr == a);
      end else begin : g_nobyp
         assign wr_hit = 1'b0;
      end

      assign rbusy[p] = busy_q[a] && !wr_hit;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with optional write-to-read forwarding
// and an integrated pending-write scoreboard for hazard detection.
module regfile_mp
   import rv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int NREGS  = NREGS_DEFAULT,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [XLEN-1:0]        wdata,
   input  logic [NUM_RD*AW-1:0]   raddr,
   output logic [NUM_RD*XLEN-1:0] rdata,
   output logic [NUM_RD-1:0]      rbusy,
   input  logic                   sb_set,
   input  logic [AW-1:0]          sb_addr,
   output logic [NREGS-1:0]       busy_vec
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wr_en_d;

   // x0 is never written, so its storage stays at the reset value of zero.
   assign wr_en_d = we && (waddr != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      end else if (wr_en_d) begin
         regs_q[waddr] <= wdata;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0] a;
      logic          fwd;

      assign a = raddr[p*AW +: AW];

      // Forwarding is gated by reset so every port reads zero while held.
      if (BYPASS != 0) begin : g_byp
         assign fwd = rst && wr_en_d && (waddr == a);
      end else begin : g_nobyp
         assign fwd = 1'b0;
      end

      assign rdata[p*XLEN +: XLEN] = fwd ? wdata : regs_q[a];
   end

   regfile_scoreboard #(
      .NREGS  (NREGS),
      .NUM_RD (NUM_RD),
      .BYPASS (BYPASS),
      .AW     (AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .sb_set   (sb_set),
      .sb_addr  (sb_addr),
      .raddr    (raddr),
      .busy_vec (busy_vec),
      .rbusy    (rbusy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding and a non-forwarding instance share one
// stimulus stream and are compared each cycle against an array-based model.
module tb_regfile_mp;

   localparam int XL = 32;
   localparam int NR = 32;
   localparam int NP = 4;
   localparam int AW = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             we = 1'b0;
   logic [AW-1:0]    waddr = '0;
   logic [XL-1:0]    wdata = '0;
   logic [NP*AW-1:0] raddr = '0;
   logic             sb_set = 1'b0;
   logic [AW-1:0]    sb_addr = '0;
   logic [NP*XL-1:0] rdata_b, rdata_n;
   logic [NP-1:0]    rbusy_b, rbusy_n;
   logic [NR-1:0]    bv_b, bv_n;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [XL-1:0] m_regs [NR];
   logic [NR-1:0] m_busy;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XL), .NREGS(NR), .NUM_RD(NP), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
      .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(bv_b));

   regfile_mp #(.XLEN(XL), .NREGS(NR), .NUM_RD(NP), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
      .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(bv_n));

   // Architectural model: x0 ignored, writer clears busy, issuer sets it after.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NR; r++) m_regs[r] <= '0;
         m_busy <= '0;
      end else begin
         if (we && waddr != 0) begin
            m_regs[waddr] <= wdata;
            m_busy[waddr] <= 1'b0;
         end
         if (sb_set && sb_addr != 0) m_busy[sb_addr] <= 1'b1;
      end
   end

   function automatic logic [XL-1:0] exp_rd(bit byp, int p);
      logic [AW-1:0] a;
      a = raddr[p*AW +: AW];
      if (!rst || a == 0) return '0;
      if (byp && we && waddr == a) return wdata;
      return m_regs[a];
   endfunction

   function automatic logic exp_rbusy(bit byp, int p);
      logic [AW-1:0] a;
      a = raddr[p*AW +: AW];
      if (!rst || a == 0) return 1'b0;
      if (byp && we && waddr == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_all();
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("rdata_byp[%0d]", p), 128'(rdata_b[p*XL +: XL]), 128'(exp_rd(1, p)));
         chk($sformatf("rdata_nobyp[%0d]", p), 128'(rdata_n[p*XL +: XL]), 128'(exp_rd(0, p)));
         chk($sformatf("rbusy_byp[%0d]", p), 128'(rbusy_b[p]), 128'(exp_rbusy(1, p)));
         chk($sformatf("rbusy_nobyp[%0d]", p), 128'(rbusy_n[p]), 128'(exp_rbusy(0, p)));
      end
      chk("busy_vec_byp", 128'(bv_b), 128'(rst ? m_busy : '0));
      chk("busy_vec_nobyp", 128'(bv_n), 128'(rst ? m_busy : '0));
   endtask

   always @(negedge clk) if (chk_en) compare_all();

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; sb_set = 1'b0; waddr = '0; sb_addr = '0; wdata = '0; raddr = '0;
   endtask

   initial begin
      logic [AW-1:0] r5;
      // Reset held with inputs toggling.
      repeat (6) begin
         step();
         we = 1'($urandom); waddr = AW'($urandom); wdata = $urandom;
         raddr = {waddr, waddr, AW'($urandom), AW'($urandom)};
         sb_set = 1'($urandom); sb_addr = AW'($urandom);
         chk_en = 1'b1;
         #2;
         chk("rst_rdata_byp", 128'(rdata_b), 128'(0));
         chk("rst_rdata_nobyp", 128'(rdata_n), 128'(0));
         chk("rst_rbusy", 128'({rbusy_b, rbusy_n}), 128'(0));
         chk("rst_busy_vec", 128'(bv_b), 128'(0));
      end
      step(); idle(); #2; rst = 1'b1;

      for (int r = 1; r < NR; r++) begin
         step(); r5 = AW'(r); raddr = {4{r5}}; #2;
         chk("init_read", 128'(rdata_b), 128'(0));
      end

      // Write x5, read next cycle.
      step(); we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      step(); we = 1'b0; raddr = 20'd5; #2;
      chk("x5_read", 128'(rdata_b[31:0]), 128'(32'hDEADBEEF));
      chk("x5_model", 128'(m_regs[5]), 128'(32'hDEADBEEF));

      // x0 write ignored, even with forwarding.
      step(); we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr = '0; #2;
      chk("x0_same_cycle", 128'({rdata_b, rdata_n}), 128'(0));
      step(); we = 1'b0; #2;
      chk("x0_next_cycle", 128'(rdata_b[31:0]), 128'(0));

      // Same-cycle forwarding vs. stored value.
      step(); we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = 20'd7; #2;
      chk("bypass_hit", 128'(rdata_b[31:0]), 128'(32'hA5A5A5A5));
      chk("nobypass_old", 128'(rdata_n[31:0]), 128'(0));
      step(); we = 1'b0; #2;
      chk("nobypass_next", 128'(rdata_n[31:0]), 128'(32'hA5A5A5A5));

      // Scoreboard set and clear on x3.
      step(); sb_set = 1'b1; sb_addr = 5'd3;
      step(); sb_set = 1'b0; raddr = 20'd3; #2;
      chk("sb_rbusy_x3", 128'(rbusy_b[0]), 128'(1));
      chk("sb_busy_vec_x3", 128'(bv_b), 128'(32'h00000008));
      step(); we = 1'b1; waddr = 5'd3; wdata = 32'h3; #2;
      chk("sb_clear_byp_rbusy", 128'(rbusy_b[0]), 128'(0));
      chk("sb_clear_nobyp_rbusy", 128'(rbusy_n[0]), 128'(1));
      step(); we = 1'b0; #2;
      chk("sb_cleared", 128'(bv_b), 128'(0));

      // Simultaneous set and clear on x9; set on x0 ignored.
      step(); sb_set = 1'b1; sb_addr = 5'd9;
      step(); we = 1'b1; waddr = 5'd9; wdata = 32'h99;
      step(); we = 1'b0; sb_set = 1'b0; raddr = 20'd9; #2;
      chk("setclr_busy_vec", 128'(bv_b), 128'(32'h00000200));
      chk("setclr_data", 128'(rdata_b[31:0]), 128'(32'h99));
      step(); sb_set = 1'b1; sb_addr = 5'd0;
      step(); sb_set = 1'b0; #2;
      chk("sb_x0_ignored", 128'(bv_b), 128'(32'h00000200));
      step(); we = 1'b1; waddr = 5'd9; wdata = 32'h99;

      // Four-port reads.
      for (int i = 1; i <= 4; i++) begin
         step(); we = 1'b1; waddr = AW'(i); wdata = 32'h11 * i;
      end
      step(); we = 1'b0; raddr = {5'd1, 5'd2, 5'd3, 5'd4}; #2;
      chk("mp_distinct", 128'(rdata_b), {32'h11, 32'h22, 32'h33, 32'h44});
      chk("mp_distinct_nb", 128'(rdata_n), {32'h11, 32'h22, 32'h33, 32'h44});
      step(); raddr = {4{5'd2}}; #2;
      chk("mp_same", 128'(rdata_b), {4{32'h22}});

      // Random traffic, with reads biased toward the write index.
      repeat (1500) begin
         step();
         we = ($urandom_range(0, 3) != 0); waddr = AW'($urandom_range(0, 15));
         wdata = $urandom; sb_set = 1'($urandom); sb_addr = AW'($urandom_range(0, 15));
         for (int p = 0; p < NP; p++)
            raddr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 15));
      end

      // Asynchronous reset between edges with a write in flight.
      step(); we = 1'b1; waddr = 5'd6; wdata = 32'hCAFEF00D;
      sb_set = 1'b1; sb_addr = 5'd6; raddr = {4{5'd6}};
      #1; rst = 1'b0; #1;
      chk("async_rdata_byp", 128'(rdata_b), 128'(0));
      chk("async_rdata_nobyp", 128'(rdata_n), 128'(0));
      chk("async_rbusy", 128'({rbusy_b, rbusy_n}), 128'(0));
      chk("async_busy_vec", 128'({bv_b, bv_n}), 128'(0));
      step(); we = 1'b0; sb_set = 1'b0; rst = 1'b1; #2;
      chk("async_write_lost", 128'(rdata_b), 128'(0));
      chk("async_set_lost", 128'(bv_b), 128'(0));
      step();
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file with an integrated pending-write scoreboard.
- Generation after the fixed 2-read/1-write 32x32 register file; sits between instruction decode and execute.
- Decode reads operands and marks destination registers pending. Writeback writes results and clears pending bits.
- Adds configurable write-to-read bypass and per-port busy flags, so a pipelined core can detect hazards.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, 2..64.
- NUM_RD, 2, number of independent read ports; 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns stored value only.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset (low = reset asserted).
- we  in  1  write enable.
- waddr  in  AW  write register index.
- wdata  in  XLEN  write data.
- raddr  in  NUM_RD*AW  packed read indices; port i uses slice [i*AW +: AW].
- rdata  out  NUM_RD*XLEN  packed read data; port i uses slice [i*XLEN +: XLEN].
- rbusy  out  NUM_RD  per-port flag: addressed register has an outstanding producer.
- sb_set  in  1  mark sb_addr pending (issued instruction writes this register).
- sb_addr  in  AW  scoreboard set index.
- busy_vec  out  NREGS  full scoreboard state, for debug and stall logic.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers cleared to 0; busy_vec cleared to 0.
  - rdata reads 0 for every port; rbusy is 0.
  - Reset asserted mid-operation discards any in-flight write or set on that edge.
- Register 0:
  - hardwired zero; writes with waddr==0 are ignored.
  - busy_vec[0] is always 0; sb_set with sb_addr==0 is ignored.
  - a read of index 0 returns 0 and rbusy 0, regardless of BYPASS.
- Write:
  - on a rising clk edge with rst high, we=1 and waddr!=0, wdata is stored in reg[waddr].
  - visible through the array from the next cycle.
- Read: combinational, zero latency.
  - BYPASS=0: rdata_i = reg[raddr_i].
  - BYPASS=1: rdata_i = wdata when we=1, waddr==raddr_i and raddr_i!=0; otherwise reg[raddr_i].
  - Multiple ports reading the same index all receive the same value.
- Scoreboard update on a rising clk edge, per index r != 0:
  - next busy[r] = (sb_set & sb_addr==r) | (busy[r] & ~(we & waddr==r)).
  - Set and clear of the same index in one cycle: set wins (a new producer supersedes the completing one).
  - A write to a non-busy register is legal; busy stays 0.
  - sb_set on an already-busy register keeps it busy.
- rbusy_i:
  - BYPASS=1: busy[raddr_i] & ~(we & waddr==raddr_i).
  - BYPASS=0: busy[raddr_i].
  - A same-cycle sb_set is not reflected until the next cycle.
- Width rules:
  - no arithmetic on data; indices are compared at full AW width.
  - out-of-range indices cannot occur because NREGS is a power of two.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN_DEFAULT=32 and NREGS_DEFAULT=32.
  - typedef reg_idx_t (5-bit) and typedef xword_t (32-bit), for use by the decoder and writeback stages.
- One natural sub-module: regfile_scoreboard, containing the busy_vec register, the set/clear logic and the busy lookup.
- Storage array, write logic and read/bypass muxes stay in regfile_mp, with a generate loop over NUM_RD.

Test Plan:
- Reset:
  - hold rst=0 with random inputs toggling.
  - required: all rdata=0, rbusy=0, busy_vec=0.
  - release rst, read x1..x31: all 0.
- Write/read, x0:
  - write x5=0xDEADBEEF; next cycle, port0 raddr=5 returns 0xDEADBEEF.
  - write x0=0x12345678; required: x0 reads 0.
- Bypass:
  - BYPASS=1: we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7 in the same cycle; required: rdata0=0xA5A5A5A5 combinationally.
  - BYPASS=0 instance: same stimulus returns the old value 0 in that cycle and 0xA5A5A5A5 the next cycle.
- Scoreboard:
  - sb_set x3; next cycle rbusy for raddr=3 is 1 and busy_vec=0x00000008.
  - we to x3; with BYPASS=1, rbusy=0 in that cycle; busy_vec=0 the cycle after.
- Simultaneous set and clear:
  - x9 busy, then in one cycle we=1/waddr=9 and sb_set/sb_addr=9.
  - required: busy_vec[9] stays 1 and x9 holds the new wdata.
  - sb_set to x0 leaves busy_vec[0]=0.
- Multi-port with NUM_RD=4:
  - write x1..x4 = 0x11, 0x22, 0x33, 0x44; read ports set to 4,3,2,1 → 0x44, 0x33, 0x22, 0x11.
  - all ports at raddr=2 → all return 0x22.
- Async reset mid-traffic:
  - drop rst between clock edges while we=1; outputs go to 0 immediately, without waiting for an edge.
  - the pending write is lost.
